// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receive path. A 2-FF synchronizer feeds an
// edge detector; the FSM locks its sampling phase to the middle of the start
// bit and then samples every OVERSAMPLE ticks. Completed bytes are offered
// on a valid/ready handshake. Framing and overrun errors are reported as
// 1-clk pulses.
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// after the data bits. The parity result is reported on parity_err.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  state_t               state_next;
  logic                 sync1;
  logic                 rs;
  logic                 rs_d;
  logic [CW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;

  logic                 fall_edge;
  logic                 half_hit;
  logic                 full_hit;
  logic                 shift_en;
  logic                 stop_en;
  logic                 cnt_clr;

  // Two-stage synchronizer plus one delay stage for edge detection; idle-high reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rs    <= 1'b1;
      rs_d  <= 1'b1;
    end else begin
      sync1 <= rx;
      rs    <= sync1;
      rs_d  <= rs;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fall_edge) state_next = START;
      // Mid start bit: a line already back high was only a glitch
      START:   if (half_hit) state_next = rs ? IDLE : DATA;
      DATA:    if (full_hit && bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                 state_next = PARITY;
`else
                 state_next = STOP;
`endif
               end
      PARITY:  if (full_hit) state_next = STOP;
      // Leave at mid-stop so a back-to-back start edge is not missed
      STOP:    if (full_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM output decode: sampling strobes and counter control
  always_comb begin
    fall_edge = rs_d & ~rs;
    half_hit  = sample_tick && (tick_cnt == HALF_LAST);
    full_hit  = sample_tick && (tick_cnt == FULL_LAST);
    shift_en  = (state == DATA) && full_hit;
    stop_en   = (state == STOP) && full_hit;
    cnt_clr   = (state_next != state) || (state == IDLE);
  end

  // Tick counter: restarts on every state entry, wraps once per bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           tick_cnt <= '0;
    else if (cnt_clr)     tick_cnt <= '0;
    else if (sample_tick) tick_cnt <= (tick_cnt == FULL_LAST) ? '0 : tick_cnt + CW'(1);
  end

  // Bit counter and LSB-first shift register (new bit enters at the MSB)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (state == START && state_next == DATA) bit_cnt <= '0;
      else if (shift_en)                        bit_cnt <= bit_cnt + BW'(1);
      if (shift_en) shift <= {rs, shift[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_en;
  assign par_en = (state == PARITY) && full_hit;

  // Even parity: data XOR parity bit must be 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      par_bad <= 1'b0;
    else if (par_en) par_bad <= (^shift) ^ rs;
  end

  // Parity error pulse, suppressed when the stop bit is also bad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= stop_en & rs & par_bad;
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Completion and handshake: deliver, drop with overrun, or flag framing error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (stop_en) begin
        if (!rs) begin
          frame_err <= 1'b1;
        end else if (!par_bad) begin
          if (!rx_valid || rx_ready) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a frame-level model of
// the receiver (expected held byte, pulse counts, accepted-byte list).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DB = 8;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // start edge -> rx_valid: 3 clks sync/edge, half start bit, data(+parity), stop
  localparam int LAT = 3 + OS / 2 + OS * (DB + PB) + OS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b1;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: pulse-high cycle counts, valid rise time, handshakes
  int            fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, rise_cyc = 0, acc_n = 0;
  logic          prev_valid = 1'b0;
  logic [DB-1:0] acc_mem [0:255];
  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun)    ov_cnt++;
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
    if (rx_valid && rx_ready) begin
      acc_mem[acc_n % 256] = rx_data;
      acc_n++;
    end
  end

  // Reference model state
  logic          m_valid = 1'b0;
  logic [DB-1:0] m_data = '0;
  int            e_fe = 0, e_pe = 0, e_ov = 0, exp_total = 0, rd_idx = 0;
  logic [DB-1:0] exp_q [$];
  int            n_vec = 0, n_err = 0, n_frm = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input logic [DB-1:0] b);
    exp_q.push_back(b);
    exp_total++;
  endtask

  task automatic check_all(input string tag);
    logic [DB-1:0] e;
    chk({tag, ".valid"}, rx_valid, m_valid);
    chk({tag, ".data"}, rx_data, m_data);
    chk({tag, ".frame_err"}, fe_cnt, e_fe);
    chk({tag, ".parity_err"}, pe_cnt, e_pe);
    chk({tag, ".overrun"}, ov_cnt, e_ov);
    chk({tag, ".acc_cnt"}, acc_n, exp_total);
    while (rd_idx < acc_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".acc_data"}, acc_mem[rd_idx % 256], e);
      rd_idx++;
    end
  endtask

  // Drive one frame; optional 1-clk ready pulse at clock index rdy_at; then idle gap
  task automatic frame(input logic [DB-1:0] b, input logic stop_v, input logic pflip,
                       input logic rdy, input int rdy_at, input int gap);
    logic [15:0] bits;
    int          nb, start_cyc;
    logic        ready_done, fresh;
    nb = 2 + DB + PB;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1 + i] = b[i];
`ifdef UART_RX_PARITY_EN
    bits[1 + DB] = (^b) ^ pflip;
`endif
    bits[nb - 1] = stop_v;
    rx_ready = rdy;
    if (rdy && m_valid) begin
      push_acc(m_data);
      m_valid = 1'b0;
    end
    start_cyc = 0;
    for (int i = 0; i < nb * OS; i++) begin
      step();
      if (i == 0) start_cyc = cyc;
      rx = bits[i / OS];
      if (i == rdy_at) rx_ready = 1'b1;
      else if (rdy_at >= 0 && i == rdy_at + 1) rx_ready = 1'b0;
    end
    // Model the completion at mid-stop
    ready_done = rdy || (rdy_at == LAT - 1);
    fresh = 1'b0;
    if (!stop_v) e_fe++;
    else if (PB != 0 && pflip) e_pe++;
    else if (ready_done) begin
      if (m_valid) push_acc(m_data);
      fresh = !m_valid;
      m_data = b;
      if (rdy) begin
        push_acc(b);
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
      end
    end else if (!m_valid) begin
      fresh = 1'b1;
      m_valid = 1'b1;
      m_data = b;
    end else begin
      e_ov++;
    end
    if (fresh) chk("latency", rise_cyc - start_cyc, LAT);
    check_all("frame");
    $display("frame %0d: byte=%02h stop=%0b pflip=%0b ready=%0b -> valid=%0b rx_data=%02h fe=%0d pe=%0d ov=%0d",
             n_frm, b, stop_v, pflip, rdy, rx_valid, rx_data, fe_cnt, pe_cnt, ov_cnt);
    n_frm++;
    for (int i = 0; i < gap; i++) begin
      step();
      rx = 1'b1;
    end
  endtask

  initial begin
    logic [DB-1:0] b;
    logic          sv, pf, rd;
    int            gp;

    // Reset values
    repeat (3) step();
    chk("rst.valid", rx_valid, 1'b0);
    chk("rst.data", rx_data, 8'h00);
    chk("rst.frame_err", frame_err, 1'b0);
    chk("rst.overrun", overrun, 1'b0);
    chk("rst.parity_err", parity_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) step();

    // Basic byte with consumer ready
    frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, 4);

    // Short low glitch on idle line
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    repeat (30) step();
    check_all("glitch");
    frame(8'h96, 1'b1, 1'b0, 1'b1, -1, 3);

    // Bad stop bit, then line held low: no retrigger until a fresh edge
    frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, 0);
    repeat (60) step();
    check_all("held_low");
    rx = 1'b1;
    repeat (10) step();
    frame(8'h66, 1'b1, 1'b0, 1'b1, -1, 2);

    // Overrun: consumer stalled across two back-to-back frames
    frame(8'h11, 1'b1, 1'b0, 1'b0, -1, 0);
    frame(8'h22, 1'b1, 1'b0, 1'b0, -1, 5);
    rx_ready = 1'b1;
    push_acc(m_data);
    m_valid = 1'b0;
    step();
    check_all("accept");

    // Accept and delivery in the same clock
    frame(8'h11, 1'b1, 1'b0, 1'b0, -1, 0);
    frame(8'h22, 1'b1, 1'b0, 1'b0, LAT - 1, 5);

    // Asynchronous reset in the middle of the data bits
    b = 8'hC3;
    for (int i = 0; i < 4 * OS; i++) begin
      step();
      rx = (i < OS) ? 1'b0 : b[i / OS - 1];
    end
    rst_n = 1'b0;
    #1;
    chk("arst.valid", rx_valid, 1'b0);
    chk("arst.data", rx_data, 8'h00);
    chk("arst.frame_err", frame_err, 1'b0);
    chk("arst.overrun", overrun, 1'b0);
    chk("arst.parity_err", parity_err, 1'b0);
    rx = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    m_valid = 1'b0;
    m_data = '0;
    check_all("post_rst");
    frame(8'h5A, 1'b1, 1'b0, 1'b0, -1, 2);
    rx_ready = 1'b1;
    push_acc(m_data);
    m_valid = 1'b0;
    step();
    check_all("accept2");

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b0, 1'b1, -1, 2);
    frame(8'h07, 1'b1, 1'b1, 1'b1, -1, 2);
    frame(8'h07, 1'b0, 1'b1, 1'b1, -1, 3);
`endif

    // Randomized frames: data, stop errors, parity errors, stalls, gaps
    for (int n = 0; n < 24; n++) begin
      b  = DB'($urandom_range(0, 255));
      sv = ($urandom_range(0, 7) != 0);
      pf = (PB != 0) && ($urandom_range(0, 7) == 0);
      rd = 1'($urandom_range(0, 1));
      gp = sv ? int'($urandom_range(0, 5)) : int'($urandom_range(2, 10));
      frame(b, sv, pf, rd, -1, gp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
